// File: rtl/ctrl_pkg.sv
// Shared constants and types for the ADC SPI sampler.
// Holds the FSM state encodings, the ADC frame geometry and the frame layout struct.
package ctrl_pkg;

  localparam int unsigned ADC_FRAME_BITS  = 16;
  localparam int unsigned ADC_LEAD_ZEROS  = 4;
  localparam int unsigned ADC_RESULT_BITS = 12;
  localparam int unsigned SAMPLE_WIDTH    = 8;
  localparam int unsigned STATE_W         = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETUP   = 3'd1;
  localparam logic [STATE_W-1:0] ST_SCLK_LO = 3'd2;
  localparam logic [STATE_W-1:0] ST_SCLK_HI = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

  // One received ADC frame, MSB first: leading zeros then the conversion result.
  typedef struct packed {
    logic [ADC_LEAD_ZEROS-1:0]  lead;
    logic [ADC_RESULT_BITS-1:0] result;
  } adc_frame_t;

endpackage

// File: rtl/adc_spi_sampler_if.sv
// Bundle between the sampler, the serial ADC and the downstream filter.
//   adc_sdo     : ADC serial data (async to clk)
//   adc_cs_n    : ADC chip select, active-low
//   adc_sclk    : SPI clock, idles high
//   measurement : latest 8-bit sample
//   valid       : one-cycle new-sample strobe
//   frame_err   : one-cycle leading-zero failure strobe
//   busy        : frame in progress
// master = sampler side, slave = ADC/filter side.
interface adc_spi_sampler_if;
  import ctrl_pkg::*;

  logic                    adc_sdo;
  logic                    adc_cs_n;
  logic                    adc_sclk;
  logic [SAMPLE_WIDTH-1:0] measurement;
  logic                    valid;
  logic                    frame_err;
  logic                    busy;

  modport master (
    input  adc_sdo,
    output adc_cs_n, adc_sclk, measurement, valid, frame_err, busy
  );

  modport slave (
    output adc_sdo,
    input  adc_cs_n, adc_sclk, measurement, valid, frame_err, busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, parameterizable width.
//   clk   : destination clock
//   rst_n : async active-low reset, clears both stages to 0
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic SPI master for a 12-bit serial ADC (16-clock frame, 4 leading zeros).
// Each frame becomes an 8-bit sample (result[11:4]) with a one-cycle valid strobe,
// or a one-cycle frame_err strobe when the leading zeros are not all zero.
//   clk    : system clock
//   rst    : async active-low reset
//   enable : sampling enable; a frame already started always completes
//   bus    : SPI pins and sample outputs (master modport)
module adc_spi_sampler
  import ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  adc_spi_sampler_if.master bus
);

  localparam int unsigned TIMER_W = $clog2(SAMPLE_PERIOD);
  localparam int unsigned HP_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W   = $clog2(ADC_FRAME_BITS);

  if (CLK_DIV < 2) begin : g_chk_div
    $error("adc_spi_sampler: CLK_DIV must be at least 2");
  end
  if (SAMPLE_PERIOD < 33 * CLK_DIV + 2) begin : g_chk_period
    $error("adc_spi_sampler: SAMPLE_PERIOD must be at least 33*CLK_DIV+2");
  end

  logic [STATE_W-1:0]      state, state_nxt;
  logic [TIMER_W-1:0]      timer, timer_nxt;
  logic [HP_W-1:0]         hp_cnt, hp_nxt;
  logic [BIT_W-1:0]        bit_cnt, bit_nxt;
  adc_frame_t              shift, shift_nxt;
  logic [SAMPLE_WIDTH-1:0] meas_nxt;
  logic                    valid_nxt, ferr_nxt, cs_n_nxt, sclk_nxt, busy_nxt;
  logic                    sdo_sync, launch, half_done;

  sync_2ff #(.WIDTH(1)) u_sdo_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (bus.adc_sdo),
    .q     (sdo_sync)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      timer           <= '0;
      hp_cnt          <= '0;
      bit_cnt         <= '0;
      shift           <= '0;
      bus.measurement <= '0;
      bus.valid       <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.adc_cs_n    <= 1'b1;
      bus.adc_sclk    <= 1'b1;
      bus.busy        <= 1'b0;
    end else begin
      state           <= state_nxt;
      timer           <= timer_nxt;
      hp_cnt          <= hp_nxt;
      bit_cnt         <= bit_nxt;
      shift           <= shift_nxt;
      bus.measurement <= meas_nxt;
      bus.valid       <= valid_nxt;
      bus.frame_err   <= ferr_nxt;
      bus.adc_cs_n    <= cs_n_nxt;
      bus.adc_sclk    <= sclk_nxt;
      bus.busy        <= busy_nxt;
    end
  end

  // Next-state logic; outputs are decoded from the next state so pins are glitch-free.
  always_comb begin
    state_nxt = state;
    hp_nxt    = hp_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    meas_nxt  = bus.measurement;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    timer_nxt = '0;

    half_done = (hp_cnt == HP_W'(CLK_DIV - 1));
    launch    = (timer == '0) && enable && (state == ST_IDLE);

    // Free-running sample-period timer, parked at 0 while disabled.
    if (enable) begin
      timer_nxt = (timer == TIMER_W'(SAMPLE_PERIOD - 1)) ? '0 : timer + TIMER_W'(1);
    end

    case (state)
      ST_IDLE: begin
        if (launch) begin
          state_nxt = ST_SETUP;
          hp_nxt    = '0;
          bit_nxt   = '0;
        end
      end
      ST_SETUP: begin
        if (half_done) begin
          state_nxt = ST_SCLK_LO;
          hp_nxt    = '0;
        end else begin
          hp_nxt = hp_cnt + HP_W'(1);
        end
      end
      ST_SCLK_LO: begin
        if (half_done) begin
          state_nxt = ST_SCLK_HI;
          hp_nxt    = '0;
        end else begin
          hp_nxt = hp_cnt + HP_W'(1);
        end
      end
      ST_SCLK_HI: begin
        // Sample as late as possible in the high phase to cover the synchronizer delay.
        if (half_done) begin
          shift_nxt = adc_frame_t'({shift[ADC_FRAME_BITS-2:0], sdo_sync});
          hp_nxt    = '0;
          if (bit_cnt == BIT_W'(ADC_FRAME_BITS - 1)) begin
            state_nxt = ST_DONE;
          end else begin
            bit_nxt   = bit_cnt + BIT_W'(1);
            state_nxt = ST_SCLK_LO;
          end
        end else begin
          hp_nxt = hp_cnt + HP_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Result is judged on entry to DONE so the strobe lines up with the DONE cycle.
    if (state_nxt == ST_DONE) begin
      if (shift_nxt.lead == '0) begin
        meas_nxt  = shift_nxt.result[ADC_RESULT_BITS-1 -: SAMPLE_WIDTH];
        valid_nxt = 1'b1;
      end else begin
        ferr_nxt = 1'b1;
      end
    end

    cs_n_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
    sclk_nxt = (state_nxt != ST_SCLK_LO);
    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule
